// File: rtl/stage_seq_if.sv
// Handshake bundle between the RK16 core top level and the stage sequencer.
// The master is the core/debug side; the sequencer connects as slave.
interface stage_seq_if;
  logic       run;
  logic       step;
  logic       halt_req;
  logic       mem_ready;
  logic       dbg_req;
  logic       dbg_gnt;
  logic [3:0] stage;
  logic       inst_we;
  logic       pc_we;
  logic       reg_we;
  logic       halted;
  logic       timeout;

  modport master (
    output run, step, halt_req, mem_ready, dbg_req,
    input  dbg_gnt, stage, inst_we, pc_we, reg_we, halted, timeout
  );

  modport slave (
    input  run, step, halt_req, mem_ready, dbg_req,
    output dbg_gnt, stage, inst_we, pc_we, reg_we, halted, timeout
  );
endinterface

// File: rtl/stage_seq.sv
// RK16 four-stage instruction sequencer: one-hot stage drive, memory stalls with timeout,
// run/halt/single-step and debug port steal. Optional RK16_SEQ_PERF_EN adds a retired counter.
module stage_seq #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  stage_seq_if.slave  bus
`ifdef RK16_SEQ_PERF_EN
  ,
  output logic [15:0] retired
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DBG  = 3'd5
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  state_t              state_r;
  state_t              state_nxt_s;
  state_t              bnd_nxt_s;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [WAIT_W-1:0]   wait_cnt_nxt_s;
  logic                token_r;
  logic                token_nxt_s;
  logic                timeout_r;
  logic                timeout_nxt_s;
  logic                pending_s;

  // State, stall counter, step token and sticky timeout registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= '0;
      token_r    <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      token_r    <= token_nxt_s;
      timeout_r  <= timeout_nxt_s;
    end
  end

  // Next state, stall counting, token and timeout bookkeeping
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = '0;
    token_nxt_s    = token_r;
    timeout_nxt_s  = timeout_r;
    bnd_nxt_s      = IDLE;

    // A step seen while idle counts as pending in the same cycle, so it starts without delay.
    pending_s = token_r | ((state_r == IDLE) & bus.step);

    if (bus.halt_req) begin
      bnd_nxt_s = IDLE;
    end else if (bus.dbg_req) begin
      bnd_nxt_s = DBG;
    end else if (bus.run | pending_s) begin
      bnd_nxt_s = S0;
    end else begin
      bnd_nxt_s = IDLE;
    end

    case (state_r)
      IDLE: state_nxt_s = bnd_nxt_s;
      S0, S1, S2: begin
        if (bus.mem_ready) begin
          case (state_r)
            S0:      state_nxt_s = S1;
            S1:      state_nxt_s = S2;
            default: state_nxt_s = S3;
          endcase
        end else if (wait_cnt_r == WAIT_LIM) begin
          state_nxt_s   = IDLE;
          timeout_nxt_s = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      S3:  state_nxt_s = bnd_nxt_s;
      DBG: begin
        if (bus.dbg_req) begin
          state_nxt_s = DBG;
        end else begin
          state_nxt_s = bnd_nxt_s;
        end
      end
      default: state_nxt_s = IDLE;
    endcase

    if (state_nxt_s == S0) begin
      token_nxt_s = 1'b0;
    end else if ((state_r == IDLE) && bus.step) begin
      token_nxt_s = 1'b1;
    end else begin
      token_nxt_s = token_r;
    end

    if ((state_r == IDLE) && (state_nxt_s == S0)) begin
      timeout_nxt_s = 1'b0;
    end else begin
      timeout_nxt_s = timeout_nxt_s;
    end
  end

  // One-hot stage decode from the state register
  always_comb begin
    bus.stage = 4'b0000;
    case (state_r)
      S0:      bus.stage = 4'b0001;
      S1:      bus.stage = 4'b0010;
      S2:      bus.stage = 4'b0100;
      S3:      bus.stage = 4'b1000;
      default: bus.stage = 4'b0000;
    endcase
  end

  assign bus.dbg_gnt = (state_r == DBG);
  assign bus.halted  = (state_r == IDLE);
  assign bus.pc_we   = (state_r == S3);
  assign bus.reg_we  = (state_r == S3);
  assign bus.inst_we = (state_r == S0) & bus.mem_ready;
  assign bus.timeout = timeout_r;

`ifdef RK16_SEQ_PERF_EN
  // Retired-instruction counter, one per writeback, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= 16'h0000;
    end else if (state_r == S3) begin
      retired <= retired + 16'h0001;
    end else begin
      retired <= retired;
    end
  end
`endif

endmodule

// File: tb/tb_stage_seq.sv
// Scoreboard bench for stage_seq: directed cycle vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_stage_seq;

  typedef struct packed {
    logic [3:0]  stage;
    logic        dbg_gnt;
    logic        inst_we;
    logic        pc_we;
    logic        reg_we;
    logic        halted;
    logic        timeout;
    logic [15:0] retired;
  } exp_t;

  localparam logic [3:0] PN = 4'b0000;
  localparam logic [3:0] P0 = 4'b0001;
  localparam logic [3:0] P1 = 4'b0010;
  localparam logic [3:0] P2 = 4'b0100;
  localparam logic [3:0] P3 = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mon_en = 1'b0;
  logic [15:0] exp_ret = 16'h0000;
  logic [15:0] obs_ret;
  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n = 0;

  stage_seq_if sif ();

`ifdef RK16_SEQ_PERF_EN
  logic [15:0] retired;
  stage_seq #(.WAIT_MAX(15), .WAIT_W(8)) dut (.clk(clk), .rst(rst), .bus(sif), .retired(retired));
  assign obs_ret = retired;
`else
  stage_seq #(.WAIT_MAX(15), .WAIT_W(8)) dut (.clk(clk), .rst(rst), .bus(sif));
  assign obs_ret = 16'h0000;
`endif

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic c(input logic r, input logic rn, input logic st, input logic hq,
                   input logic mr, input logic dq, input logic [3:0] es, input logic eg,
                   input logic eiw, input logic epw, input logic erw, input logic eh,
                   input logic eto);
    exp_t e;
    rst           = r;
    sif.run       = rn;
    sif.step      = st;
    sif.halt_req  = hq;
    sif.mem_ready = mr;
    sif.dbg_req   = dq;
    e.stage   = es;
    e.dbg_gnt = eg;
    e.inst_we = eiw;
    e.pc_we   = epw;
    e.reg_we  = erw;
    e.halted  = eh;
    e.timeout = eto;
`ifdef RK16_SEQ_PERF_EN
    e.retired = exp_ret;
`else
    e.retired = 16'h0000;
`endif
    sb_q.push_back(e);
    if (r) exp_ret = 16'h0000;
    else if (epw) exp_ret = exp_ret + 16'h0001;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      exp_t o;
      cyc_n = cyc_n + 1;
      checks = checks + 1;
      o = {sif.stage, sif.dbg_gnt, sif.inst_we, sif.pc_we, sif.reg_we, sif.halted,
           sif.timeout, obs_ret};
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb_underflow cycle %0d: output seen with no expectation queued", cyc_n);
      end else begin
        e = sb_q.pop_front();
        if (o !== e) begin
          errors = errors + 1;
          $display("FAIL cycle %0d: got stage=%b gnt=%b iwe=%b pwe=%b rwe=%b halted=%b to=%b ret=%0d; expected stage=%b gnt=%b iwe=%b pwe=%b rwe=%b halted=%b to=%b ret=%0d",
                   cyc_n, o.stage, o.dbg_gnt, o.inst_we, o.pc_we, o.reg_we, o.halted, o.timeout,
                   o.retired, e.stage, e.dbg_gnt, e.inst_we, e.pc_we, e.reg_we, e.halted,
                   e.timeout, e.retired);
        end
      end
    end
  end

  initial begin
    sif.run = 1'b0; sif.step = 1'b0; sif.halt_req = 1'b0;
    sif.mem_ready = 1'b0; sif.dbg_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // reset state, then free run with no stalls
    c(1,0,0,0,0,0, PN,0,0,0,0,1,0);
    c(0,1,0,0,1,0, PN,0,0,0,0,1,0);
    for (int k = 0; k < 2; k++) begin
      c(0,1,0,0,1,0, P0,0,1,0,0,0,0);
      c(0,1,0,0,1,0, P1,0,0,0,0,0,0);
      c(0,1,0,0,1,0, P2,0,0,0,0,0,0);
      c(0,1,0,0,1,0, P3,0,0,1,1,0,0);
    end
    // three stall cycles in S1, then stop at the boundary
    c(0,1,0,0,1,0, P0,0,1,0,0,0,0);
    for (int k = 0; k < 3; k++) c(0,1,0,0,0,0, P1,0,0,0,0,0,0);
    c(0,1,0,0,1,0, P1,0,0,0,0,0,0);
    c(0,1,0,0,1,0, P2,0,0,0,0,0,0);
    c(0,0,0,0,1,0, P3,0,0,1,1,0,0);
    c(0,0,0,0,1,0, PN,0,0,0,0,1,0);
    // memory stuck in S2: 15 counted stalls then timeout
    c(0,1,0,0,1,0, PN,0,0,0,0,1,0);
    c(0,1,0,0,1,0, P0,0,1,0,0,0,0);
    c(0,1,0,0,1,0, P1,0,0,0,0,0,0);
    for (int k = 0; k < 16; k++) c(0,0,0,0,0,0, P2,0,0,0,0,0,0);
    c(0,0,0,0,0,0, PN,0,0,0,0,1,1);
    c(0,0,0,0,1,0, PN,0,0,0,0,1,1);
    // single step clears timeout; second step while busy ignored
    c(0,0,1,0,1,0, PN,0,0,0,0,1,1);
    c(0,0,0,0,1,0, P0,0,1,0,0,0,0);
    c(0,0,1,0,1,0, P1,0,0,0,0,0,0);
    c(0,0,0,0,1,0, P2,0,0,0,0,0,0);
    c(0,0,0,0,1,0, P3,0,0,1,1,0,0);
    c(0,0,0,0,1,0, PN,0,0,0,0,1,0);
    c(0,0,0,0,1,0, PN,0,0,0,0,1,0);
    // mem_ready arriving exactly at the stall limit wins over timeout
    c(0,0,1,0,0,0, PN,0,0,0,0,1,0);
    for (int k = 0; k < 15; k++) c(0,0,0,0,0,0, P0,0,0,0,0,0,0);
    c(0,0,0,0,1,0, P0,0,1,0,0,0,0);
    c(0,0,0,0,1,0, P1,0,0,0,0,0,0);
    c(0,0,0,0,1,0, P2,0,0,0,0,0,0);
    c(0,0,0,0,1,0, P3,0,0,1,1,0,0);
    c(0,0,0,0,1,0, PN,0,0,0,0,1,0);
    // debug request mid-instruction granted only after S3
    c(0,1,0,0,1,0, PN,0,0,0,0,1,0);
    c(0,1,0,0,1,0, P0,0,1,0,0,0,0);
    c(0,1,0,0,1,1, P1,0,0,0,0,0,0);
    c(0,1,0,0,1,1, P2,0,0,0,0,0,0);
    c(0,1,0,0,1,1, P3,0,0,1,1,0,0);
    c(0,1,0,0,1,1, PN,1,0,0,0,0,0);
    c(0,1,0,0,1,0, PN,1,0,0,0,0,0);
    c(0,0,0,0,1,0, P0,0,1,0,0,0,0);
    c(0,0,0,0,1,0, P1,0,0,0,0,0,0);
    c(0,0,0,0,1,0, P2,0,0,0,0,0,0);
    c(0,0,0,0,1,0, P3,0,0,1,1,0,0);
    c(0,0,0,0,1,0, PN,0,0,0,0,1,0);
    // step with debug pending: debug first, token kept for one instruction
    c(0,0,1,0,1,1, PN,0,0,0,0,1,0);
    c(0,0,0,0,1,1, PN,1,0,0,0,0,0);
    c(0,0,0,0,1,0, PN,1,0,0,0,0,0);
    c(0,0,0,0,1,0, P0,0,1,0,0,0,0);
    c(0,0,0,0,1,0, P1,0,0,0,0,0,0);
    c(0,0,0,0,1,0, P2,0,0,0,0,0,0);
    c(0,0,0,0,1,0, P3,0,0,1,1,0,0);
    c(0,0,0,0,1,0, PN,0,0,0,0,1,0);
    // halt_req at the boundary stops a running core and holds it idle
    c(0,1,0,0,1,0, PN,0,0,0,0,1,0);
    c(0,1,0,0,1,0, P0,0,1,0,0,0,0);
    c(0,1,0,0,1,0, P1,0,0,0,0,0,0);
    c(0,1,0,0,1,0, P2,0,0,0,0,0,0);
    c(0,1,0,1,1,0, P3,0,0,1,1,0,0);
    c(0,1,0,1,1,0, PN,0,0,0,0,1,0);
    c(0,1,0,0,1,0, PN,0,0,0,0,1,0);
    c(0,1,0,0,1,0, P0,0,1,0,0,0,0);
    c(0,1,0,0,1,0, P1,0,0,0,0,0,0);
    // reset in S2 aborts the instruction without commit
    c(1,1,0,0,1,0, P2,0,0,0,0,0,0);
    c(0,0,0,0,1,0, PN,0,0,0,0,1,0);
    c(0,0,0,0,1,0, PN,0,0,0,0,1,0);

    mon_en = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
